// File: rtl/game_flow_controller.sv
// Frogger game flow FSM: sequences start, death, level-up and game-over, owning lives, level and lane directions.
// Latency: all outputs registered; each state change lands on the clock edge after the qualifying input rise.
// Backpressure: none; level inputs are sampled every cycle and i_Frame_Tick paces the DYING/LEVEL_UP countdowns.
module game_flow_controller #(
    parameter int C_LIVES          = 3,
    parameter int C_RESPAWN_FRAMES = 60,
    parameter int C_LEVELUP_FRAMES = 90,
    parameter int C_MAX_LEVEL      = 9
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Frame_Tick,
    input  logic       i_Start,
    input  logic       i_Has_Collided,
    input  logic       i_Reached_Goal,
    input  logic [3:0] i_LFSR_Data,
    output logic       o_Game_Active,
    output logic       o_Freeze,
    output logic       o_Respawn,
    output logic [2:0] o_Lives,
    output logic [3:0] o_Level,
    output logic [3:0] o_Reverse,
    output logic       o_Game_Over,
    output logic [2:0] o_State
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUNNING   = 3'd1,
        DYING     = 3'd2,
        LEVEL_UP  = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    typedef struct packed {
        state_t     state;
        logic [2:0] lives;
        logic [3:0] level;
        logic [3:0] reverse;
        logic       respawn;
        logic       active;
        logic       freeze;
        logic       game_over;
        logic [7:0] frame_cnt;
    } flow_t;

    localparam logic [2:0] LIVES_INIT   = 3'((1 << C_LIVES) - 1);
    localparam logic [3:0] REVERSE_INIT = 4'b1010;
    localparam logic [3:0] MAX_LEVEL    = 4'(C_MAX_LEVEL);
    localparam logic [7:0] RESPAWN_LAST = 8'(C_RESPAWN_FRAMES - 1);
    localparam logic [7:0] LEVELUP_LAST = 8'(C_LEVELUP_FRAMES - 1);

    flow_t cur;
    flow_t nxt;

    logic start_q;
    logic coll_q;
    logic goal_q;
    logic start_armed;
    logic start_rise;
    logic coll_rise;
    logic goal_rise;
    logic [7:0] frame_last;

    // start_armed blocks a start level that was already high when reset released
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            start_q     <= 1'b0;
            coll_q      <= 1'b0;
            goal_q      <= 1'b0;
            start_armed <= 1'b0;
        end else begin
            start_q     <= i_Start;
            coll_q      <= i_Has_Collided;
            goal_q      <= i_Reached_Goal;
            start_armed <= start_armed | ~i_Start;
        end
    end

    assign start_rise = i_Start & ~start_q & start_armed;
    assign coll_rise  = i_Has_Collided & ~coll_q;
    assign goal_rise  = i_Reached_Goal & ~goal_q;
    assign frame_last = (cur.state == DYING) ? RESPAWN_LAST : LEVELUP_LAST;

    always_comb begin
        nxt         = cur;
        nxt.respawn = 1'b0;
        case (cur.state)
            IDLE, GAME_OVER: begin
                if (start_rise) begin
                    nxt.state     = RUNNING;
                    nxt.lives     = LIVES_INIT;
                    nxt.level     = 4'd0;
                    nxt.reverse   = REVERSE_INIT;
                    nxt.respawn   = 1'b1;
                    nxt.frame_cnt = 8'd0;
                end
            end
            RUNNING: begin
                // collision wins over a simultaneous goal
                if (coll_rise) begin
                    nxt.lives     = cur.lives >> 1;
                    nxt.frame_cnt = 8'd0;
                    nxt.state     = ((cur.lives >> 1) == 3'b000) ? GAME_OVER : DYING;
                end else if (goal_rise) begin
                    nxt.state     = LEVEL_UP;
                    nxt.frame_cnt = 8'd0;
                    nxt.level     = (cur.level >= MAX_LEVEL) ? MAX_LEVEL : cur.level + 4'd1;
                    nxt.reverse   = (i_LFSR_Data == 4'b0000) ? REVERSE_INIT : i_LFSR_Data;
                end
            end
            DYING, LEVEL_UP: begin
                if (i_Frame_Tick) begin
                    if (cur.frame_cnt == frame_last) begin
                        nxt.state     = RUNNING;
                        nxt.respawn   = 1'b1;
                        nxt.frame_cnt = 8'd0;
                    end else begin
                        nxt.frame_cnt = cur.frame_cnt + 8'd1;
                    end
                end
            end
            default: begin
                nxt.state     = IDLE;
                nxt.frame_cnt = 8'd0;
            end
        endcase
        nxt.active    = (nxt.state == RUNNING);
        nxt.freeze    = (nxt.state != RUNNING);
        nxt.game_over = (nxt.state == GAME_OVER);
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            cur.state     <= IDLE;
            cur.lives     <= 3'b111;
            cur.level     <= 4'd0;
            cur.reverse   <= REVERSE_INIT;
            cur.respawn   <= 1'b0;
            cur.active    <= 1'b0;
            cur.freeze    <= 1'b1;
            cur.game_over <= 1'b0;
            cur.frame_cnt <= 8'd0;
        end else begin
            cur <= nxt;
        end
    end

    assign o_State       = cur.state;
    assign o_Lives       = cur.lives;
    assign o_Level       = cur.level;
    assign o_Reverse     = cur.reverse;
    assign o_Respawn     = cur.respawn;
    assign o_Game_Active = cur.active;
    assign o_Freeze      = cur.freeze;
    assign o_Game_Over   = cur.game_over;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed scenarios plus randomized play against a frame-level game model.
module tb_game_flow_controller;

    localparam int RESPAWN = 60;
    localparam int LEVELUP = 90;
    localparam int MAXLVL  = 9;
    localparam int LIVES   = 3;

    logic       i_Clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Frame_Tick = 1'b0;
    logic       i_Start = 1'b0;
    logic       i_Has_Collided = 1'b0;
    logic       i_Reached_Goal = 1'b0;
    logic [3:0] i_LFSR_Data = 4'd0;
    logic       o_Game_Active, o_Freeze, o_Respawn, o_Game_Over;
    logic [2:0] o_Lives, o_State;
    logic [3:0] o_Level, o_Reverse;

    int errors = 0;
    int checks = 0;

    // reference model: lives as a count, countdown as elapsed ticks
    int       m_state, m_nlives, m_level, m_ticks;
    logic [3:0] m_rev;
    bit       m_respawn, m_armed, m_sp, m_cp, m_gp;

    game_flow_controller dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Frame_Tick(i_Frame_Tick), .i_Start(i_Start),
        .i_Has_Collided(i_Has_Collided), .i_Reached_Goal(i_Reached_Goal), .i_LFSR_Data(i_LFSR_Data),
        .o_Game_Active(o_Game_Active), .o_Freeze(o_Freeze), .o_Respawn(o_Respawn), .o_Lives(o_Lives),
        .o_Level(o_Level), .o_Reverse(o_Reverse), .o_Game_Over(o_Game_Over), .o_State(o_State)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic logic [2:0] m_lives();
        return 3'((1 << m_nlives) - 1);
    endfunction

    task automatic model_reset();
        m_state = 0; m_nlives = 3; m_level = 0; m_ticks = 0; m_rev = 4'b1010;
        m_respawn = 0; m_armed = 0; m_sp = 0; m_cp = 0; m_gp = 0;
    endtask

    task automatic model_clock(input bit s, input bit c, input bit g, input bit t, input logic [3:0] l);
        bit s_rise, c_rise, g_rise;
        s_rise = s && !m_sp && m_armed;
        c_rise = c && !m_cp;
        g_rise = g && !m_gp;
        m_respawn = 0;
        if (m_state == 0 || m_state == 4) begin
            if (s_rise) begin
                m_state = 1; m_nlives = LIVES; m_level = 0; m_rev = 4'b1010; m_respawn = 1;
            end
        end else if (m_state == 1) begin
            if (c_rise) begin
                m_nlives = m_nlives - 1;
                m_ticks = 0;
                m_state = (m_nlives == 0) ? 4 : 2;
            end else if (g_rise) begin
                m_state = 3; m_ticks = 0;
                m_level = (m_level + 1 > MAXLVL) ? MAXLVL : m_level + 1;
                m_rev = (l == 4'd0) ? 4'b1010 : l;
            end
        end else if (t) begin
            m_ticks = m_ticks + 1;
            if (m_ticks == ((m_state == 2) ? RESPAWN : LEVELUP)) begin
                m_state = 1; m_respawn = 1; m_ticks = 0;
            end
        end
        if (!s) m_armed = 1;
        m_sp = s; m_cp = c; m_gp = g;
    endtask

    task automatic step(input bit s, input bit c, input bit g, input bit t, input logic [3:0] l);
        i_Start = s; i_Has_Collided = c; i_Reached_Goal = g; i_Frame_Tick = t; i_LFSR_Data = l;
        @(posedge i_Clk);
        model_clock(s, c, g, t, l);
        @(negedge i_Clk);
    endtask

    task automatic do_reset(input bit s);
        i_Reset = 1; i_Start = s; i_Has_Collided = 0; i_Reached_Goal = 0; i_Frame_Tick = 0;
        model_reset();
        repeat (2) @(negedge i_Clk);
        i_Reset = 0;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 4'($urandom_range(15)));
    endtask

    task automatic start_game();
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset(0);
        checks++; if (o_State !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", o_State); end
        checks++; if (o_Lives !== 3'b111) begin errors++; $display("FAIL reset_lives: got %b expected 111", o_Lives); end
        checks++; if (o_Level !== 4'd0 || o_Reverse !== 4'b1010) begin errors++; $display("FAIL reset_lvl_rev: got %0d/%b expected 0/1010", o_Level, o_Reverse); end
        checks++; if ({o_Respawn, o_Game_Active, o_Freeze, o_Game_Over} !== 4'b0010) begin errors++; $display("FAIL reset_flags: got %b expected 0010", {o_Respawn, o_Game_Active, o_Freeze, o_Game_Over}); end
    endtask

    task automatic test_start();
        do_reset(0);
        step(0, 0, 0, 0, 0);
        checks++; if (o_State !== 3'd0) begin errors++; $display("FAIL start_pre: got %0d expected 0", o_State); end
        step(1, 0, 0, 0, 0);
        checks++; if (o_State !== 3'd1 || o_Lives !== 3'b111) begin errors++; $display("FAIL start_run: got %0d/%b expected 1/111", o_State, o_Lives); end
        checks++; if ({o_Respawn, o_Game_Active, o_Freeze} !== 3'b110) begin errors++; $display("FAIL start_flags: got %b expected 110", {o_Respawn, o_Game_Active, o_Freeze}); end
        step(1, 0, 0, 0, 0);
        checks++; if (o_Respawn !== 1'b0 || o_State !== 3'd1) begin errors++; $display("FAIL start_pulse_width: got %b/%0d expected 0/1", o_Respawn, o_State); end
    endtask

    task automatic test_three_deaths();
        logic [2:0] exp_l;
        do_reset(0);
        start_game();
        for (int k = 0; k < 3; k++) begin
            exp_l = 3'b111 >> (k + 1);
            step(0, 1, 0, 0, 0);
            checks++; if (o_Lives !== exp_l) begin errors++; $display("FAIL death_lives%0d: got %b expected %b", k, o_Lives, exp_l); end
            if (k < 2) begin
                checks++; if (o_State !== 3'd2) begin errors++; $display("FAIL death_state%0d: got %0d expected 2", k, o_State); end
                step(0, 0, 0, 0, 0);
                run_ticks(RESPAWN - 1);
                checks++; if (o_State !== 3'd2 || o_Respawn !== 1'b0) begin errors++; $display("FAIL death_tick59_%0d: got %0d/%b expected 2/0", k, o_State, o_Respawn); end
                step(0, 0, 0, 1, 0);
                checks++; if (o_State !== 3'd1 || o_Respawn !== 1'b1) begin errors++; $display("FAIL death_respawn%0d: got %0d/%b expected 1/1", k, o_State, o_Respawn); end
            end else begin
                checks++; if (o_State !== 3'd4 || o_Game_Over !== 1'b1 || o_Freeze !== 1'b1) begin errors++; $display("FAIL game_over: got %0d/%b/%b expected 4/1/1", o_State, o_Game_Over, o_Freeze); end
            end
        end
    endtask

    task automatic test_level_saturation();
        int exp_lvl;
        do_reset(0);
        start_game();
        for (int k = 0; k < 10; k++) begin
            exp_lvl = (k + 1 > MAXLVL) ? MAXLVL : k + 1;
            step(0, 0, 1, 0, 4'($urandom_range(15)));
            checks++; if (o_Level !== 4'(exp_lvl) || o_State !== 3'd3) begin errors++; $display("FAIL level%0d: got %0d/%0d expected %0d/3", k, o_Level, o_State, exp_lvl); end
            step(0, 0, 0, 0, 0);
            run_ticks(LEVELUP);
            checks++; if (o_State !== 3'd1 || o_Respawn !== 1'b1) begin errors++; $display("FAIL levelup_end%0d: got %0d/%b expected 1/1", k, o_State, o_Respawn); end
        end
    endtask

    task automatic test_lfsr_zero();
        do_reset(0);
        start_game();
        step(0, 0, 1, 0, 4'b0000);
        checks++; if (o_Reverse !== 4'b1010) begin errors++; $display("FAIL lfsr_zero: got %b expected 1010", o_Reverse); end
        step(0, 0, 0, 0, 0);
        run_ticks(LEVELUP);
        step(0, 0, 1, 0, 4'b0110);
        checks++; if (o_Reverse !== 4'b0110) begin errors++; $display("FAIL lfsr_0110: got %b expected 0110", o_Reverse); end
    endtask

    task automatic test_simultaneous();
        do_reset(0);
        start_game();
        step(0, 0, 1, 0, 4'b0011);
        step(0, 0, 0, 0, 0);
        run_ticks(LEVELUP);
        step(0, 1, 1, 0, 4'b0101);
        checks++; if (o_State !== 3'd2 || o_Level !== 4'd1 || o_Lives !== 3'b011) begin errors++; $display("FAIL simultaneous: got %0d/%0d/%b expected 2/1/011", o_State, o_Level, o_Lives); end
        checks++; if (o_Reverse !== 4'b0011) begin errors++; $display("FAIL simultaneous_rev: got %b expected 0011", o_Reverse); end
    endtask

    task automatic test_collision_held();
        do_reset(0);
        start_game();
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < RESPAWN; i++) step(0, 1, 0, 1, 0);
        checks++; if (o_State !== 3'd1 || o_Respawn !== 1'b1) begin errors++; $display("FAIL held_respawn: got %0d/%b expected 1/1", o_State, o_Respawn); end
        repeat (5) step(0, 1, 0, 0, 0);
        checks++; if (o_State !== 3'd1 || o_Lives !== 3'b011) begin errors++; $display("FAIL held_no_loss: got %0d/%b expected 1/011", o_State, o_Lives); end
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        checks++; if (o_State !== 3'd2 || o_Lives !== 3'b001) begin errors++; $display("FAIL held_new_edge: got %0d/%b expected 2/001", o_State, o_Lives); end
    endtask

    task automatic test_ignored_edges();
        do_reset(1);
        repeat (5) step(1, 0, 0, 0, 0);
        checks++; if (o_State !== 3'd0 || o_Respawn !== 1'b0) begin errors++; $display("FAIL start_held_reset: got %0d/%b expected 0/0", o_State, o_Respawn); end
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        checks++; if (o_State !== 3'd1) begin errors++; $display("FAIL start_after_fall: got %0d expected 1", o_State); end
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        checks++; if (o_State !== 3'd1 || o_Respawn !== 1'b0) begin errors++; $display("FAIL start_in_running: got %0d/%b expected 1/0", o_State, o_Respawn); end
        step(0, 1, 0, 0, 0);
        step(1, 0, 1, 1, 4'b1111);
        checks++; if (o_State !== 3'd2 || o_Level !== 4'd0 || o_Reverse !== 4'b1010) begin errors++; $display("FAIL edges_in_dying: got %0d/%0d/%b expected 2/0/1010", o_State, o_Level, o_Reverse); end
    endtask

    task automatic test_reset_mid_countdown();
        do_reset(0);
        start_game();
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        run_ticks(30);
        i_Frame_Tick = 0;
        i_Reset = 1;
        #1;
        checks++; if (o_State !== 3'd0 || o_Lives !== 3'b111 || o_Respawn !== 1'b0) begin errors++; $display("FAIL midreset_async: got %0d/%b/%b expected 0/111/0", o_State, o_Lives, o_Respawn); end
        model_reset();
        @(negedge i_Clk);
        i_Reset = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 0);
            checks++; if (o_State !== 3'd0 || o_Respawn !== 1'b0) begin errors++; $display("FAIL midreset_release%0d: got %0d/%b expected 0/0", i, o_State, o_Respawn); end
        end
    endtask

    task automatic test_random();
        bit s, c, g, prev_rsp;
        logic [18:0] exp_v, act_v;
        s = 0; c = 0; g = 0; prev_rsp = 0;
        do_reset(0);
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(15) == 0) s = !s;
            if ($urandom_range(11) == 0) c = !c;
            if ($urandom_range(11) == 0) g = !g;
            step(s, c, g, ($urandom_range(2) == 0), 4'($urandom_range(15)));
            exp_v = {3'(m_state), m_lives(), 4'(m_level), m_rev, m_respawn,
                     (m_state == 1), (m_state != 1), (m_state == 4)};
            act_v = {o_State, o_Lives, o_Level, o_Reverse, o_Respawn, o_Game_Active, o_Freeze, o_Game_Over};
            checks++; if (act_v !== exp_v) begin errors++; $display("FAIL random_cycle%0d: got %h expected %h", n, act_v, exp_v); end
            checks++; if (prev_rsp && o_Respawn) begin errors++; $display("FAIL respawn_double%0d: got 1 expected 0", n); end
            prev_rsp = o_Respawn;
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_three_deaths();
        test_level_saturation();
        test_lfsr_zero();
        test_simultaneous();
        test_collision_held();
        test_ignored_edges();
        test_reset_mid_countdown();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
